// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the SRAM request/response front-end.
//   rsp_entry_t : one buffered response, {we, rdata}, at the default data width
//   RSP_DEPTH   : response buffer depth
//   OFFSET_BITS : byte-offset bits dropped from the byte address
package mem_req_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RSP_DEPTH  = 2;

    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int OFFSET_BITS = offset_bits(DATA_WIDTH);

    typedef struct packed {
        logic                  we;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_entry_t;

endpackage

// File: rtl/mem_req_ctrl_rsp_fifo.sv
// Two-entry first-word-fall-through register FIFO for buffered responses.
//   clk_i, arst_ni : clock, async active-low reset (clears storage too)
//   push_i, push_data_i : write one entry
//   pop_i          : drop the head entry (caller guarantees count_o != 0)
//   head_o         : current head, valid while count_o != 0
//   count_o        : occupancy 0..2
module rsp_fifo
    import mem_req_ctrl_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    // Depth is fixed at RSP_DEPTH = 2, so single-bit pointers wrap naturally.
    logic [WIDTH-1:0] store_q [RSP_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                store_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                store_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Valid/ready front-end for a single-port synchronous SRAM with 1-cycle read
// latency. Accepted requests drive the SRAM pins directly; read data returns
// via a bypass path or, under back-pressure, through a 2-entry buffer.
//   req_*  : request channel (byte address, write enable, data, strobes)
//   rsp_*  : response channel (read data, echoed write enable)
//   mem_*  : SRAM pins (word address, we, wdata, wstrb, rdata)
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int OFF        = offset_bits(DATA_WIDTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDR_WIDTH+OFF-1:0] req_addr_i,
    input  logic                      req_we_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [STRB_WIDTH-1:0]     req_wstrb_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [STRB_WIDTH-1:0]     mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    logic                  inflight_q;
    logic                  inflight_we_q;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [DATA_WIDTH:0]   fifo_push_data;
    logic [2:0]            outstanding;
    logic                  accept;
    logic                  consume;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  have_buffered;

    // Credit check uses registered state only: buffered + in-flight beats.
    assign outstanding = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign req_ready_o = (outstanding < 3'd2);
    assign accept      = req_valid_i && req_ready_o;

    // The reset term keeps the SRAM from being written while ready is forced
    // high during reset.
    assign mem_addr_o  = req_addr_i[ADDR_WIDTH+OFF-1:OFF];
    assign mem_wdata_o = req_wdata_i;
    assign mem_wstrb_o = req_wstrb_i;
    assign mem_we_o    = accept && req_we_i && arst_ni;

    generate
        if (OFF > 0) begin : g_offset
            logic unused_offset;
            assign unused_offset = ^req_addr_i[OFF-1:0];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            inflight_q    <= 1'b0;
            inflight_we_q <= 1'b0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                inflight_we_q <= req_we_i;
            end
        end
    end

    assign have_buffered = (fifo_count != 2'd0);
    assign rsp_valid_o   = have_buffered || inflight_q;
    assign consume       = rsp_valid_o && rsp_ready_i;

    // Buffered entries are older than the in-flight beat, so the bypass is
    // only used when the buffer is empty. Idle output is forced to zero.
    always_comb begin
        rsp_rdata_o = '0;
        rsp_we_o    = 1'b0;
        if (have_buffered) begin
            rsp_rdata_o = fifo_head[DATA_WIDTH-1:0];
            rsp_we_o    = fifo_head[DATA_WIDTH];
        end else if (inflight_q) begin
            rsp_rdata_o = mem_rdata_i;
            rsp_we_o    = inflight_we_q;
        end
    end

    assign fifo_push      = inflight_q && !(!have_buffered && consume);
    assign fifo_pop       = have_buffered && consume;
    assign fifo_push_data = {inflight_we_q, mem_rdata_i};

    rsp_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;
    import mem_req_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [17:0] req_addr_i;
    logic        req_we_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_we_o;
    logic [15:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    bit mon_en = 1'b0;

    logic [31:0] sram   [256];
    logic [31:0] shadow [256];
    rsp_entry_t  sb_q [$];

    mem_req_ctrl dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_we_o    (rsp_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model: synchronous read returning pre-write contents.
    always @(posedge clk_i) begin
        mem_rdata_i <= sram[mem_addr_o[7:0]];
        if (mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb_o[b]) sram[mem_addr_o[7:0]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: expected responses pushed at accept, popped on consume.
    always @(negedge clk_i) begin
        rsp_entry_t e;
        logic       exp_ready;
        int         idx;
        if (arst_ni && mon_en) begin
            exp_ready = (sb_q.size() < 2);
            chk("req_ready", req_ready_o, exp_ready);
            chk("rsp_valid", rsp_valid_o, sb_q.size() != 0);
            chk("mem_we", mem_we_o, req_valid_i && exp_ready && req_we_i);
            if (sb_q.size() != 0) begin
                chk("rsp_rdata", rsp_rdata_o, sb_q[0].rdata);
                chk("rsp_we", rsp_we_o, sb_q[0].we);
                if (rsp_ready_i) void'(sb_q.pop_front());
            end
            if (req_valid_i && exp_ready) begin
                idx     = int'(req_addr_i[9:2]);
                e.we    = req_we_i;
                e.rdata = shadow[idx];
                sb_q.push_back(e);
                accepts++;
                if (req_we_i) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_wstrb_i[b]) shadow[idx][b*8 +: 8] = req_wdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    task automatic send(input logic we, input logic [17:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
        logic acc;
        acc         = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_wstrb_i = wstrb;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            acc = req_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) break;
        end
        chk("accept_bound", acc, 1'b1);
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk_i);
            #1;
        end
        chk("drain_bound", sb_q.size(), 0);
    endtask

    initial begin
        int acc_before;
        for (int i = 0; i < 256; i++) begin
            sram[i]   = $urandom;
            shadow[i] = sram[i];
        end
        arst_ni     = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 18'h00010;
        req_wdata_i = 32'h0;
        req_wstrb_i = 4'hF;
        rsp_ready_i = 1'b1;
        #12;
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_rsp_we", rsp_we_o, 1'b0);
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        @(posedge clk_i);
        #2;
        arst_ni = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk_i);
        #1;

        // Full write, then read back.
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 18'h00010;
        req_wdata_i = 32'hDEADBEEF;
        req_wstrb_i = 4'hF;
        @(negedge clk_i);
        chk("wr_mem_addr", mem_addr_o, 16'h0004);
        chk("wr_mem_we", mem_we_o, 1'b1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        @(negedge clk_i);
        chk("wr_we_pulse", mem_we_o, 1'b0);
        chk("wr_rsp_valid", rsp_valid_o, 1'b1);
        chk("wr_rsp_we", rsp_we_o, 1'b1);
        @(posedge clk_i);
        #1;
        send(1'b0, 18'h00010, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("rd_valid_n1", rsp_valid_o, 1'b1);
        chk("rd_data_n1", rsp_rdata_o, 32'hDEADBEEF);
        @(posedge clk_i);
        #1;

        // Partial strobe merge.
        send(1'b1, 18'h00010, 32'h11223344, 4'b0101);
        send(1'b0, 18'h00012, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("partial_data", rsp_rdata_o, 32'hDE22BE44);
        @(posedge clk_i);
        #1;
        wait_drain();

        // Back-to-back writes then reads of consecutive words.
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1'b1;
            req_we_i    = 1'b1;
            req_addr_i  = 18'h00020 + 18'(4 * i);
            req_wdata_i = 32'hA0000000 + 32'h01010101 * i;
            req_wstrb_i = 4'hF;
            @(negedge clk_i);
            chk("b2b_wr_ready", req_ready_o, 1'b1);
            @(posedge clk_i);
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1'b1;
            req_we_i    = 1'b0;
            req_addr_i  = 18'h00020 + 18'(4 * i);
            @(negedge clk_i);
            chk("b2b_rd_ready", req_ready_o, 1'b1);
            chk("b2b_rsp_valid", rsp_valid_o, 1'b1);
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_last_data", rsp_rdata_o, 32'hA7070707);
        @(posedge clk_i);
        #1;
        wait_drain();

        // Back-pressure with a stream of distinct write requests.
        rsp_ready_i = 1'b0;
        acc_before  = accepts;
        for (int k = 0; k < 6; k++) begin
            req_valid_i = 1'b1;
            req_we_i    = 1'b1;
            req_addr_i  = 18'h00040 + 18'(4 * k);
            req_wdata_i = 32'h5A5A0000 + 32'(k);
            req_wstrb_i = 4'hF;
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
        chk("bp_accepts", accepts - acc_before, 2);
        chk("bp_ready_low", req_ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        rsp_ready_i = 1'b1;
        wait_drain();

        // Push and pop in the same cycle keep one entry buffered.
        rsp_ready_i = 1'b0;
        send(1'b0, 18'h00020, 32'h0, 4'h0);
        send(1'b0, 18'h00024, 32'h0, 4'h0);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("pushpop_count", dut.fifo_count, 2'd1);
        @(negedge clk_i);
        chk("pushpop_next", rsp_rdata_o, 32'hA1010101);
        @(posedge clk_i);
        #1;
        wait_drain();

        // Asynchronous reset with a full buffer.
        rsp_ready_i = 1'b0;
        send(1'b0, 18'h00028, 32'h0, 4'h0);
        send(1'b0, 18'h0002C, 32'h0, 4'h0);
        @(posedge clk_i);
        #1;
        chk("full_count", dut.fifo_count, 2'd2);
        #1;
        arst_ni = 1'b0;
        #1;
        chk("async_rsp_valid", rsp_valid_o, 1'b0);
        chk("async_req_ready", req_ready_o, 1'b1);
        chk("async_rsp_rdata", rsp_rdata_o, 32'h0);
        sb_q.delete();
        @(posedge clk_i);
        #2;
        arst_ni     = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        send(1'b0, 18'h00010, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("post_rst_data", rsp_rdata_o, 32'hDE22BE44);
        @(posedge clk_i);
        #1;
        wait_drain();
        @(negedge clk_i);
        chk("post_rst_idle", rsp_valid_o, 1'b0);

        mon_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("sram_contents", sram[i], shadow[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
